// File: rtl/dmem_dump_engine.sv
// Streams every data-memory word, in ascending address order, over a valid/ready port.
// Build option DMEM_DUMP_CHECKSUM_EN appends a modular-sum beat after the last word.
module dmem_dump_engine #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W:0]   out_addr,
  output logic              out_last
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FIN} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic              infl_q, infl_d;
  logic [ADDR_W-1:0] infl_addr_q;
  logic [1:0]        cnt_q, cnt_d;
  logic              head_q, head_d;
  logic              tail_q, tail_d;
  logic [DATA_W-1:0] fifo_data_q [2];
  logic [ADDR_W:0]   fifo_addr_q [2];
  logic              fifo_last_q [2];

  logic              issue, pop, push, push_last, csum_pend;
  logic [DATA_W-1:0] push_data;
  logic [ADDR_W:0]   push_addr;
  logic [1:0]        occ;

  assign pop = (cnt_q != 2'd0) && out_ready;
  assign occ = cnt_q + {1'b0, infl_q};

`ifdef DMEM_DUMP_CHECKSUM_EN
  localparam logic [ADDR_W:0] CSUM_ADDR = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] sum_q;
  logic              csum_pend_q;
  logic              csum_push;
  logic              start_acc;

  assign start_acc = (state_q == IDLE) && start;
  // The sum beat waits until the final word has landed in the buffer and a slot is free.
  assign csum_push = (state_q == DRAIN) && csum_pend_q && !infl_q &&
                     ((cnt_q != 2'd2) || pop);
  assign csum_pend = csum_pend_q;
  assign push      = infl_q || csum_push;
  assign push_data = infl_q ? mem_rdata : sum_q;
  assign push_addr = infl_q ? {1'b0, infl_addr_q} : CSUM_ADDR;
  assign push_last = !infl_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sum_q       <= '0;
      csum_pend_q <= 1'b0;
    end else begin
      if (start_acc)   sum_q <= '0;
      else if (infl_q) sum_q <= sum_q + mem_rdata;
      if (start_acc || csum_push)              csum_pend_q <= 1'b0;
      else if (issue && rd_ptr_q == LAST_ADDR) csum_pend_q <= 1'b1;
    end
  end
`else
  assign csum_pend = 1'b0;
  assign push      = infl_q;
  assign push_data = mem_rdata;
  assign push_addr = {1'b0, infl_addr_q};
  assign push_last = (infl_addr_q == LAST_ADDR);
`endif

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    issue    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SCAN;
          rd_ptr_d = '0;
        end
      end
      SCAN: begin
        // A pop this cycle frees a slot, so a full buffer may still issue.
        if ((occ < 2'd2) || pop) begin
          issue = 1'b1;
          if (rd_ptr_q == LAST_ADDR) state_d = DRAIN;
          else                       rd_ptr_d = rd_ptr_q + 1'b1;
        end
      end
      DRAIN: begin
        if ((cnt_q == 2'd0) && !infl_q && !csum_pend) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    infl_d = issue;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (pop)  head_d = ~head_q;
    if (push) tail_d = ~tail_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      infl_q   <= 1'b0;
      cnt_q    <= 2'd0;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      infl_q   <= infl_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
    end
  end

  // Read stage -> buffer stage: word storage needs no reset, occupancy gates it.
  always_ff @(posedge CLK) begin
    if (issue) infl_addr_q <= rd_ptr_q;
    if (push) begin
      fifo_data_q[tail_q] <= push_data;
      fifo_addr_q[tail_q] <= push_addr;
      fifo_last_q[tail_q] <= push_last;
    end
  end

  assign busy      = (state_q == SCAN) || (state_q == DRAIN);
  assign done      = (state_q == FIN);
  assign mem_rd_en = issue;
  assign mem_addr  = issue ? rd_ptr_q : '0;
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = out_valid ? fifo_data_q[head_q] : '0;
  assign out_addr  = out_valid ? fifo_addr_q[head_q] : '0;
  assign out_last  = out_valid ? fifo_last_q[head_q] : 1'b0;

endmodule
